// File: rtl/clock_div_pkg.sv
// Shared state encoding and divisor clamping helpers for clock_div_prog.
// clamp_high is used only when CLKDIV_DUTY_EN is defined.
package clock_div_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : div;
  endfunction

  // High time must leave at least one low cycle in the period.
  function automatic logic [31:0] clamp_high(input logic [31:0] high, input logic [31:0] div);
    logic [31:0] res;
    res = high;
    if (res < 32'd1) res = 32'd1;
    if (res > div - 32'd1) res = div - 32'd1;
    return res;
  endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: OFF/HIGH/LOW FSM, period counter and a one-deep config shadow.
// With CLKDIV_DUTY_EN defined the shadow takes an explicit high time; otherwise H = D>>1.
module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 250
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             ch_en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0] load_high,
`endif
  output logic             ready,
  output logic             err,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_DIV >> 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] high_reg, high_next;
  logic             pend_reg, pend_next;
  logic [CNT_W-1:0] sdiv_reg, sdiv_next;
  logic [CNT_W-1:0] shigh_reg, shigh_next;
  logic             clk_reg, clk_next;
  logic             tick_reg, tick_next;
  logic             err_reg, err_next;

  logic [CNT_W-1:0] ld_div, ld_high;
  logic             ld_clamped;
  logic             apply;

  always_comb begin
    ld_div = CNT_W'(clamp_div(32'(load_div)));
`ifdef CLKDIV_DUTY_EN
    ld_high    = CNT_W'(clamp_high(32'(load_high), 32'(ld_div)));
    ld_clamped = (ld_div != load_div) || (ld_high != load_high);
`else
    ld_high    = ld_div >> 1;
    ld_clamped = (ld_div != load_div);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_OFF;
      cnt_reg   <= '0;
      div_reg   <= DEF_D;
      high_reg  <= DEF_H;
      pend_reg  <= 1'b0;
      sdiv_reg  <= '0;
      shigh_reg <= '0;
      clk_reg   <= 1'b0;
      tick_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      div_reg   <= div_next;
      high_reg  <= high_next;
      pend_reg  <= pend_next;
      sdiv_reg  <= sdiv_next;
      shigh_reg <= shigh_next;
      clk_reg   <= clk_next;
      tick_reg  <= tick_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    div_next   = div_reg;
    high_next  = high_reg;
    pend_next  = pend_reg;
    sdiv_next  = sdiv_reg;
    shigh_next = shigh_reg;
    clk_next   = clk_reg;
    tick_next  = 1'b0;
    err_next   = load && !pend_reg && ld_clamped;
    apply      = 1'b0;

    // Load and apply are exclusive: a load needs an empty shadow, apply needs a full one.
    if (load && !pend_reg) begin
      pend_next  = 1'b1;
      sdiv_next  = ld_div;
      shigh_next = ld_high;
    end

    if (enable) begin
      if (!ch_en) begin
        state_next = ST_OFF;
        cnt_next   = '0;
        clk_next   = 1'b0;
        apply      = pend_reg;
      end else begin
        case (state_reg)
          ST_OFF: begin
            state_next = ST_HIGH;
            cnt_next   = '0;
            clk_next   = 1'b1;
            tick_next  = 1'b1;
            apply      = pend_reg;
          end
          ST_HIGH: begin
            if (cnt_reg == high_reg - CNT_W'(1)) begin
              state_next = ST_LOW;
              cnt_next   = '0;
              clk_next   = 1'b0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          ST_LOW: begin
            if (cnt_reg == div_reg - high_reg - CNT_W'(1)) begin
              state_next = ST_HIGH;
              cnt_next   = '0;
              clk_next   = 1'b1;
              tick_next  = 1'b1;
              apply      = pend_reg;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          default: begin
            state_next = ST_OFF;
            cnt_next   = '0;
            clk_next   = 1'b0;
          end
        endcase
      end
    end

    if (apply) begin
      div_next  = sdiv_reg;
      high_next = shigh_reg;
      pend_next = 1'b0;
    end
  end

  assign ready   = !pend_reg;
  assign err     = err_reg;
  assign clk_out = clk_reg;
  assign tick    = tick_reg;

endmodule

// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock divider with glitch-free run-time divisor updates.
// Define CLKDIV_DUTY_EN to add the cfg_high port for programmable high time.
module clock_div_prog
  import clock_div_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 250,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0]  cfg_high,
`endif
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] chan_ready;
  logic [NUM_CH-1:0] chan_err;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign sel[gi] = (cfg_ch == CH_W'(gi));

      clock_div_chan #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
      ) u_chan (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .ch_en     (ch_en[gi]),
        .load      (cfg_valid & sel[gi] & chan_ready[gi]),
        .load_div  (cfg_div),
`ifdef CLKDIV_DUTY_EN
        .load_high (cfg_high),
`endif
        .ready     (chan_ready[gi]),
        .err       (chan_err[gi]),
        .clk_out   (clk_out[gi]),
        .tick      (tick[gi])
      );
    end
  endgenerate

  // Out-of-range channel indices match no channel and therefore see ready=1.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel[i]) cfg_ready = chan_ready[i];
    end
  end

  assign cfg_err = |chan_err;

endmodule

// File: tb/tb_clock_div_prog.sv
// Self-checking bench for clock_div_prog: directed sequences, a vector table and random
// stimulus checked every cycle against a period-position model. Honors CLKDIV_DUTY_EN.
module tb_clock_div_prog;

  localparam int NUM_CH  = 3;
  localparam int CNT_W   = 16;
  localparam int DEF_DIV = 250;
  localparam int CH_W    = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic              cfg_valid = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
`ifdef CLKDIV_DUTY_EN
  logic [CNT_W-1:0]  cfg_high = '0;
`endif
  logic              cfg_ready;
  logic              cfg_err;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  int checks = 0;
  int errors = 0;

  // Model: each running channel is at position pos (0..D-1) of its period; high while pos < H.
  bit              m_on   [NUM_CH];
  int              m_pos  [NUM_CH];
  int              m_d    [NUM_CH];
  int              m_h    [NUM_CH];
  bit              m_pend [NUM_CH];
  int              m_sd   [NUM_CH];
  int              m_sh   [NUM_CH];
  bit [NUM_CH-1:0] m_tick;
  bit              m_err;

  typedef struct {
    int div;
    int high;
    int exp_h;
    int exp_l;
    bit exp_err;
  } vec_t;

  always #5 clock = ~clock;

  clock_div_prog #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef CLKDIV_DUTY_EN
    .cfg_high  (cfg_high),
`endif
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [NUM_CH-1:0] model_clk();
    bit [NUM_CH-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_on[c] && (m_pos[c] < m_h[c]);
    return v;
  endfunction

  function automatic bit model_ready();
    if (int'(cfg_ch) >= NUM_CH) return 1'b1;
    return !m_pend[cfg_ch];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_on[c] = 0; m_pos[c] = 0; m_d[c] = DEF_DIV; m_h[c] = DEF_DIV / 2;
      m_pend[c] = 0; m_sd[c] = 0; m_sh[c] = 0;
    end
    m_tick = '0;
    m_err = 0;
  endtask

  task automatic model_apply(input int c);
    if (m_pend[c]) begin
      m_d[c] = m_sd[c];
      m_h[c] = m_sh[c];
      m_pend[c] = 0;
    end
  endtask

  task automatic model_step(input bit rdy);
    int d;
    int h;
    bit clamped;
    if (reset) begin
      model_reset();
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_tick[c] = 0;
        if (enable) begin
          if (!ch_en[c]) begin
            m_on[c] = 0; m_pos[c] = 0; model_apply(c);
          end else if (!m_on[c]) begin
            m_on[c] = 1; m_pos[c] = 0; model_apply(c); m_tick[c] = 1;
          end else begin
            m_pos[c]++;
            if (m_pos[c] >= m_d[c]) begin
              m_pos[c] = 0; model_apply(c); m_tick[c] = 1;
            end
          end
        end
      end
      m_err = 0;
      if (cfg_valid && rdy && int'(cfg_ch) < NUM_CH) begin
        d = int'(cfg_div);
        clamped = 0;
        if (d < 2) begin d = 2; clamped = 1; end
`ifdef CLKDIV_DUTY_EN
        h = int'(cfg_high);
        if (h < 1) begin h = 1; clamped = 1; end
        if (h > d - 1) begin h = d - 1; clamped = 1; end
`else
        h = d / 2;
`endif
        m_pend[cfg_ch] = 1;
        m_sd[cfg_ch] = d;
        m_sh[cfg_ch] = h;
        m_err = clamped;
      end
    end
  endtask

  // One clock: check ready before the edge, advance model, check registered outputs after.
  task automatic cycle();
    bit rdy;
    #1;
    rdy = model_ready();
    check("cfg_ready", 32'(cfg_ready), 32'(rdy));
    @(posedge clock);
    model_step(rdy);
    #1;
    check("outputs", 32'({cfg_err, tick, clk_out}), 32'({m_err, m_tick, model_clk()}));
  endtask

  task automatic restart(input logic [NUM_CH-1:0] mask);
    reset = 1; cfg_valid = 0;
    cycle(); cycle();
    reset = 0; enable = 1; ch_en = mask;
    cycle();
  endtask

  task automatic measure_run(input int c, input logic level, input int limit, output int n);
    n = 1;
    while (n < limit) begin
      cycle();
      if (clk_out[c] !== level) break;
      n++;
    end
  endtask

  task automatic wait_tick(input int c, input int limit);
    int n;
    n = 0;
    while (tick[c] !== 1'b1 && n < limit) begin
      cycle();
      n++;
    end
    check("wait_tick", 32'(tick[c]), 32'd1);
  endtask

  initial begin
    vec_t vecs [7];
    int n;
    int n2;
    int stall;

`ifdef CLKDIV_DUTY_EN
    vecs[0] = '{10, 3, 3, 7, 1'b0};
    vecs[1] = '{10, 0, 1, 9, 1'b1};
    vecs[2] = '{10, 10, 9, 1, 1'b1};
    vecs[3] = '{1, 0, 1, 1, 1'b1};
    vecs[4] = '{5, 2, 2, 3, 1'b0};
    vecs[5] = '{6, 5, 5, 1, 1'b0};
    vecs[6] = '{3, 7, 2, 1, 1'b1};
`else
    vecs[0] = '{1, 0, 1, 1, 1'b1};
    vecs[1] = '{0, 0, 1, 1, 1'b1};
    vecs[2] = '{2, 0, 1, 1, 1'b0};
    vecs[3] = '{5, 0, 2, 3, 1'b0};
    vecs[4] = '{4, 0, 2, 2, 1'b0};
    vecs[5] = '{7, 0, 3, 4, 1'b0};
    vecs[6] = '{9, 0, 4, 5, 1'b0};
`endif

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);

    // Default divisor: 125/125, first tick one cycle after enable
    reset = 0; enable = 1; ch_en = 3'b001;
    cycle();
    check("t1_first_clk", 32'(clk_out), 32'b001);
    check("t1_first_tick", 32'(tick), 32'b001);
    measure_run(0, 1'b1, 1000, n);
    check("t1_high", n, 125);
    measure_run(0, 1'b0, 1000, n2);
    check("t1_low", n2, 125);
    check("t1_tick_period", 32'(tick[0]), 32'd1);
    $display("T1 default high=%0d low=%0d", n, n2);

    // Reprogram ch1 mid-HIGH: old period finishes first
    restart(3'b111);
    repeat (49) cycle();
    cfg_valid = 1; cfg_ch = 2'd1; cfg_div = 16'd4;
`ifdef CLKDIV_DUTY_EN
    cfg_high = 16'd2;
`endif
    cycle();
    cfg_valid = 0;
    #1;
    check("t2_pending_ready", 32'(cfg_ready), 32'd0);
    measure_run(1, 1'b1, 1000, n);
    check("t2_old_high_rest", n, 75);
    measure_run(1, 1'b0, 1000, n);
    check("t2_old_low", n, 125);
    measure_run(1, 1'b1, 1000, n);
    check("t2_new_high", n, 2);
    measure_run(1, 1'b0, 1000, n);
    check("t2_new_low", n, 2);
    check("t2_all_clk", 32'(clk_out), 32'b111);
    check("t2_tick_only_ch1", 32'(tick), 32'b010);
    $display("T2 ch1 reprogrammed to 4 at boundary");

    // Back-to-back configs on ch2: second stalls until the first applies
    restart(3'b111);
    repeat (9) cycle();
    cfg_valid = 1; cfg_ch = 2'd2; cfg_div = 16'd6;
`ifdef CLKDIV_DUTY_EN
    cfg_high = 16'd3;
`endif
    cycle();
    cfg_div = 16'd8;
`ifdef CLKDIV_DUTY_EN
    cfg_high = 16'd4;
`endif
    stall = 0;
    #1;
    while (cfg_ready !== 1'b1 && stall < 600) begin
      cycle();
      stall++;
      #1;
    end
    check("t3_stall", stall, 240);
    cycle();
    cfg_valid = 0;
    measure_run(2, 1'b1, 1000, n);
    check("t3_first_high_rest", n, 2);
    measure_run(2, 1'b0, 1000, n);
    check("t3_first_low", n, 3);
    measure_run(2, 1'b1, 1000, n);
    check("t3_second_high", n, 4);
    measure_run(2, 1'b0, 1000, n);
    check("t3_second_low", n, 4);
    $display("T3 back-to-back stall=%0d", stall);

    // Table of divisor/high-time programming with clamping
    for (int v = 0; v < 7; v++) begin
      restart(3'b000);
      cfg_valid = 1; cfg_ch = 2'd0; cfg_div = CNT_W'(vecs[v].div);
`ifdef CLKDIV_DUTY_EN
      cfg_high = CNT_W'(vecs[v].high);
`endif
      cycle();
      check("t4_err_pulse", 32'(cfg_err), 32'(vecs[v].exp_err));
      cfg_valid = 0; ch_en = 3'b001;
      cycle();
      check("t4_err_clear", 32'(cfg_err), 32'd0);
      measure_run(0, 1'b1, 100, n);
      check("t4_high", n, vecs[v].exp_h);
      measure_run(0, 1'b0, 100, n2);
      check("t4_low", n2, vecs[v].exp_l);
      check("t4_tick", 32'(tick[0]), 32'd1);
      $display("T4 vec %0d div=%0d high=%0d -> %0d/%0d", v, vecs[v].div, vecs[v].high, n, n2);
    end

    // enable=0 for 10 cycles mid-LOW stretches the period by exactly 10
    restart(3'b001);
    measure_run(0, 1'b1, 1000, n);
    check("t5_high", n, 125);
    n = 1;
    for (int i = 0; i < 400; i++) begin
      enable = (i >= 5 && i < 15) ? 1'b0 : 1'b1;
      cycle();
      if (clk_out[0] !== 1'b0) break;
      n++;
    end
    enable = 1;
    check("t5_low_stretched", n, 135);
    $display("T5 frozen low run=%0d", n);

    // Reset mid-HIGH after reprogramming restores the default divisor
    cfg_valid = 1; cfg_ch = 2'd0; cfg_div = 16'd4;
`ifdef CLKDIV_DUTY_EN
    cfg_high = 16'd2;
`endif
    cycle();
    cfg_valid = 0;
    wait_tick(0, 400);
    cycle();
    check("t6_prereset_high", 32'(clk_out[0]), 32'd1);
    reset = 1;
    cycle();
    check("t6_reset_clk", 32'(clk_out), 32'd0);
    check("t6_reset_tick", 32'(tick), 32'd0);
    reset = 0;
    cycle();
    check("t6_restart_tick", 32'(tick[0]), 32'd1);
    measure_run(0, 1'b1, 1000, n);
    check("t6_default_high", n, 125);
    $display("T6 reset mid-HIGH, high after reset=%0d", n);

    // Out-of-range channel index: ready, no effect
    cfg_valid = 1; cfg_ch = 2'd3; cfg_div = 16'd1;
    #1;
    check("t7_bad_ch_ready", 32'(cfg_ready), 32'd1);
    cycle();
    check("t7_bad_ch_err", 32'(cfg_err), 32'd0);
    cfg_valid = 0;
    $display("T7 out-of-range cfg_ch ignored");

    // Random stimulus against the model
    ch_en = '1;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 999) == 0);
      enable = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 63) == 0) ch_en[c] = ~ch_en[c];
      end
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_ch = CH_W'($urandom_range(0, 3));
      cfg_div = CNT_W'($urandom_range(0, 12));
`ifdef CLKDIV_DUTY_EN
      cfg_high = CNT_W'($urandom_range(0, 13));
`endif
      cycle();
    end
    reset = 0;
    $display("T8 random 4000 cycles done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
